// File: rtl/wb_gpio_pkg.sv
// Register offsets and reset values shared by the wb_gpio_n target and its bench.
package wb_gpio_pkg;

   localparam int unsigned GPIO_OUT_OFF   = 32'h00;
   localparam int unsigned GPIO_IN_OFF    = 32'h04;
   localparam int unsigned GPIO_DIR_OFF   = 32'h08;
   localparam int unsigned GPIO_IEN_OFF   = 32'h0C;
   localparam int unsigned GPIO_ISTAT_OFF = 32'h10;
   localparam int unsigned GPIO_IPOL_OFF  = 32'h14;
   localparam int unsigned GPIO_SET_OFF   = 32'h18;
   localparam int unsigned GPIO_CLR_OFF   = 32'h1C;

   localparam logic [31:0] GPIO_OUT_RST   = 32'h0000_0000;
   localparam logic [31:0] GPIO_DIR_RST   = 32'h0000_0000;
   localparam logic [31:0] GPIO_IEN_RST   = 32'h0000_0000;
   localparam logic [31:0] GPIO_ISTAT_RST = 32'h0000_0000;
   localparam logic [31:0] GPIO_IPOL_RST  = 32'hFFFF_FFFF;
   localparam logic [31:0] GPIO_DATR_RST  = 32'h0000_0000;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-bit, STAGES-deep flop chain that brings asynchronous pad inputs into the clock domain.
module gpio_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int k = 1; k < STAGES; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wb_gpio_n.sv
// Parametrised Wishbone GPIO target: direction, synchronised inputs, per-pin edge interrupts.
// Optional GPIO_SET_CLR_EN adds atomic OUT_SET (0x18) / OUT_CLR (0x1C) write-only registers.
module wb_gpio_n
   import wb_gpio_pkg::*;
#(
   parameter int N_GPIO      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ADR_WIDTH   = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ADR_WIDTH-1:0] adr_i,
   input  logic [31:0]          dat_w,
   output logic [31:0]          dat_r,
   input  logic                 cyc,
   input  logic                 stb,
   input  logic                 we,
   input  logic [3:0]           sel,
   output logic                 ack,
   output logic                 err,
   input  logic [N_GPIO-1:0]    gpio_in,
   output logic [N_GPIO-1:0]    gpio_out,
   output logic [N_GPIO-1:0]    gpio_oeb,
   output logic                 irq
);

   localparam logic [ADR_WIDTH-1:0] A_OUT   = ADR_WIDTH'(GPIO_OUT_OFF);
   localparam logic [ADR_WIDTH-1:0] A_IN    = ADR_WIDTH'(GPIO_IN_OFF);
   localparam logic [ADR_WIDTH-1:0] A_DIR   = ADR_WIDTH'(GPIO_DIR_OFF);
   localparam logic [ADR_WIDTH-1:0] A_IEN   = ADR_WIDTH'(GPIO_IEN_OFF);
   localparam logic [ADR_WIDTH-1:0] A_ISTAT = ADR_WIDTH'(GPIO_ISTAT_OFF);
   localparam logic [ADR_WIDTH-1:0] A_IPOL  = ADR_WIDTH'(GPIO_IPOL_OFF);
`ifdef GPIO_SET_CLR_EN
   localparam logic [ADR_WIDTH-1:0] A_SET   = ADR_WIDTH'(GPIO_SET_OFF);
   localparam logic [ADR_WIDTH-1:0] A_CLR   = ADR_WIDTH'(GPIO_CLR_OFF);
`else
   // OUT_SET/OUT_CLR offsets decode as unmapped in this build.
`endif
   localparam logic [2:0] BLANK_INIT = 3'(SYNC_STAGES + 1);

   logic [N_GPIO-1:0] out_q,   out_d;
   logic [N_GPIO-1:0] dir_q,   dir_d;
   logic [N_GPIO-1:0] ien_q,   ien_d;
   logic [N_GPIO-1:0] istat_q, istat_d;
   logic [N_GPIO-1:0] ipol_q,  ipol_d;
   logic [N_GPIO-1:0] prev_q;
   logic [2:0]        blank_q, blank_d;
   logic              ack_q;
   logic              irq_q;
   logic [31:0]       dat_r_q;

   logic [N_GPIO-1:0]    sync_in;
   logic [N_GPIO-1:0]    wmask;
   logic [N_GPIO-1:0]    wdata;
   logic [N_GPIO-1:0]    clr_mask;
   logic [N_GPIO-1:0]    edge_raw;
   logic [N_GPIO-1:0]    edge_hit;
   logic [ADR_WIDTH-1:0] word_adr;
   logic [31:0]          rd_data;
   logic                 accept;
   logic                 wr_en;
   logic                 unused_bits;

   gpio_sync #(
      .WIDTH  (N_GPIO),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clock),
      .srst_i (reset),
      .d_i    (gpio_in),
      .q_o    (sync_in)
   );

   assign accept   = cyc & stb & ~ack_q;
   assign wr_en    = accept & we;
   assign word_adr = {adr_i[ADR_WIDTH-1:2], 2'b00};
   assign wdata    = dat_w[N_GPIO-1:0];
   assign unused_bits = ^{adr_i[1:0], dat_w, sel};

   for (genvar gi = 0; gi < N_GPIO; gi++) begin : g_lane
      assign wmask[gi]    = sel[gi / 8];
      assign edge_raw[gi] = ipol_q[gi] ? (sync_in[gi] & ~prev_q[gi])
                                       : (~sync_in[gi] & prev_q[gi]);
   end

   // Output pins never log edges, and nothing is logged until the synchroniser has flushed.
   assign edge_hit = edge_raw & ~dir_q & {N_GPIO{blank_q == 3'd0}};
   assign blank_d  = (blank_q != 3'd0) ? blank_q - 3'd1 : blank_q;

   always_comb begin
      out_d    = out_q;
      dir_d    = dir_q;
      ien_d    = ien_q;
      ipol_d   = ipol_q;
      clr_mask = '0;
      if (wr_en) begin
         case (word_adr)
            A_OUT:   out_d    = (out_q  & ~wmask) | (wdata & wmask);
            A_DIR:   dir_d    = (dir_q  & ~wmask) | (wdata & wmask);
            A_IEN:   ien_d    = (ien_q  & ~wmask) | (wdata & wmask);
            A_IPOL:  ipol_d   = (ipol_q & ~wmask) | (wdata & wmask);
            A_ISTAT: clr_mask = wdata & wmask;
`ifdef GPIO_SET_CLR_EN
            A_SET:   out_d    = out_q | (wdata & wmask);
            A_CLR:   out_d    = out_q & ~(wdata & wmask);
`endif
            default: ;
         endcase
      end
      // Applying the set after the clear lets a same-cycle edge win over W1C.
      istat_d = (istat_q & ~clr_mask) | edge_hit;
   end

   always_comb begin
      rd_data = '0;
      case (word_adr)
         A_OUT:   rd_data = 32'(out_q);
         A_IN:    rd_data = 32'(sync_in);
         A_DIR:   rd_data = 32'(dir_q);
         A_IEN:   rd_data = 32'(ien_q);
         A_ISTAT: rd_data = 32'(istat_q);
         A_IPOL:  rd_data = 32'(ipol_q);
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_q   <= GPIO_OUT_RST[N_GPIO-1:0];
         dir_q   <= GPIO_DIR_RST[N_GPIO-1:0];
         ien_q   <= GPIO_IEN_RST[N_GPIO-1:0];
         istat_q <= GPIO_ISTAT_RST[N_GPIO-1:0];
         ipol_q  <= GPIO_IPOL_RST[N_GPIO-1:0];
         prev_q  <= '0;
         blank_q <= BLANK_INIT;
         ack_q   <= 1'b0;
         irq_q   <= 1'b0;
         dat_r_q <= GPIO_DATR_RST;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         ien_q   <= ien_d;
         istat_q <= istat_d;
         ipol_q  <= ipol_d;
         prev_q  <= sync_in;
         blank_q <= blank_d;
         ack_q   <= accept;
         irq_q   <= |(istat_q & ien_q);
         if (accept) begin
            dat_r_q <= rd_data;
         end
      end
   end

   assign ack      = ack_q;
   assign err      = 1'b0;
   assign dat_r    = dat_r_q;
   assign irq      = irq_q;
   assign gpio_out = out_q;
   assign gpio_oeb = ~dir_q;

endmodule

// File: tb/tb_wb_gpio_n.sv
// Directed, table-driven bench for wb_gpio_n (N_GPIO=8, SYNC_STAGES=2); follows GPIO_SET_CLR_EN if defined.
module tb_wb_gpio_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic        ack, err;
   logic [7:0]  gpio_in, gpio_out, gpio_oeb;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_gpio_n #(
      .N_GPIO      (8),
      .SYNC_STAGES (2),
      .ADR_WIDTH   (8)
   ) dut (
      .clock    (clk),
      .reset    (rst),
      .adr_i    (adr),
      .dat_w    (dat_w),
      .dat_r    (dat_r),
      .cyc      (cyc),
      .stb      (stb),
      .we       (we),
      .sel      (sel),
      .ack      (ack),
      .err      (err),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oeb (gpio_oeb),
      .irq      (irq)
   );

   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oeb;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One Wishbone access; checks ack arrives one cycle after strobe and lasts one cycle.
   task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
      int lat;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ack && lat < 20);
      rd = dat_r;
      check($sformatf("ack latency adr=%02h", a), 32'(lat), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check($sformatf("ack pulse width adr=%02h", a), 32'(ack), 32'd0);
      $display("%s adr=0x%02h wdat=0x%08h sel=%b rdat=0x%08h", w ? "WR" : "RD", a, d, s, rd);
   endtask

   task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
      check(name, rd, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      wb_xfer(1'b1, a, d, s, rd);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;

      vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'h00, 8'hFF};
      vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'h00, 8'hFF};
      vecs[2]  = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'h00, 8'hFF};
      vecs[3]  = '{1'b0, 8'h0C, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'h00, 8'hFF};
      vecs[4]  = '{1'b0, 8'h10, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'h00, 8'hFF};
      vecs[5]  = '{1'b0, 8'h14, 32'h0,        4'hF, 1'b1, 32'h0000_00FF, 8'h00, 8'hFF};
      vecs[6]  = '{1'b0, 8'h18, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'h00, 8'hFF};
      vecs[7]  = '{1'b1, 8'h08, 32'h0000_000F, 4'h1, 1'b0, 32'h0,        8'h00, 8'hF0};
      vecs[8]  = '{1'b1, 8'h00, 32'h0000_00A5, 4'h1, 1'b0, 32'h0,        8'hA5, 8'hF0};
      vecs[9]  = '{1'b1, 8'h00, 32'h0000_005A, 4'h2, 1'b0, 32'h0,        8'hA5, 8'hF0};
      vecs[10] = '{1'b0, 8'h00, 32'h0,        4'hF, 1'b1, 32'h0000_00A5, 8'hA5, 8'hF0};
      vecs[11] = '{1'b0, 8'h08, 32'h0,        4'hF, 1'b1, 32'h0000_000F, 8'hA5, 8'hF0};
      vecs[12] = '{1'b1, 8'h14, 32'h0,        4'h0, 1'b0, 32'h0,        8'hA5, 8'hF0};
      vecs[13] = '{1'b0, 8'h14, 32'h0,        4'hF, 1'b1, 32'h0000_00FF, 8'hA5, 8'hF0};
      vecs[14] = '{1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,        8'hA5, 8'hF0};
      vecs[15] = '{1'b0, 8'h20, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 8'hA5, 8'hF0};
      vecs[16] = '{1'b0, 8'h03, 32'h0,        4'hF, 1'b1, 32'h0000_00A5, 8'hA5, 8'hF0};

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
      gpio_in = 8'h00;
      idle(3);
      check("reset ack", 32'(ack), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset gpio_out", 32'(gpio_out), 32'h00);
      check("reset gpio_oeb", 32'(gpio_oeb), 32'hFF);
      check("reset dat_r", dat_r, 32'h0);
      rst = 1'b0;
      idle(5);

      for (int i = 0; i < 17; i++) begin
         wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd);
         if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
         check($sformatf("vec%0d gpio_oeb", i), 32'(gpio_oeb), 32'(vecs[i].exp_oeb));
      end

      // Rising edge on input bit 4 with its interrupt enabled.
      wr(8'h0C, 32'h10, 4'h1);
      gpio_in = 8'h10;
      idle(3);
      check("irq before status settles", 32'(irq), 32'd0);
      idle(1);
      check("irq one cycle after status", 32'(irq), 32'd1);
      rd_check("IN after rise", 8'h04, 32'h10);
      rd_check("ISTAT after rise", 8'h10, 32'h10);
      wr(8'h10, 32'h10, 4'h2);
      rd_check("ISTAT W1C unselected lane", 8'h10, 32'h10);
      wr(8'h10, 32'h10, 4'h1);
      check("irq after W1C", 32'(irq), 32'd0);
      rd_check("ISTAT after W1C", 8'h10, 32'h00);

      // Falling-edge polarity on bit 4; outputs (bits 0..3) never log edges.
      gpio_in = 8'h00;
      idle(6);
      rd_check("ISTAT fall with rising pol", 8'h10, 32'h00);
      wr(8'h14, 32'hEF, 4'h1);
      gpio_in = 8'h10;
      idle(6);
      rd_check("ISTAT rise with falling pol", 8'h10, 32'h00);
      gpio_in = 8'h00;
      idle(6);
      rd_check("ISTAT fall with falling pol", 8'h10, 32'h10);
      check("irq on falling edge", 32'(irq), 32'd1);
      wr(8'h10, 32'hFF, 4'h1);
      gpio_in = 8'h01;
      idle(6);
      rd_check("IN shows output pin pad", 8'h04, 32'h01);
      rd_check("ISTAT output pin edge", 8'h10, 32'h00);
      gpio_in = 8'h00;
      idle(6);

      // Bit 5 rising edge lands on the same edge as its W1C: set wins.
      gpio_in = 8'h20;
      idle(6);
      rd_check("ISTAT bit5 first rise", 8'h10, 32'h20);
      gpio_in = 8'h00;
      idle(6);
      @(negedge clk);
      gpio_in = 8'h20;
      @(negedge clk);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h10; dat_w = 32'h20; sel = 4'h1;
      @(negedge clk);
      check("collide ack", 32'(ack), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      $display("WR adr=0x10 wdat=0x00000020 sel=0001 (coincident with bit5 edge)");
      idle(1);
      rd_check("ISTAT set beats clear", 8'h10, 32'h20);
      wr(8'h10, 32'h20, 4'h1);
      rd_check("ISTAT cleared without edge", 8'h10, 32'h00);

`ifdef GPIO_SET_CLR_EN
      wr(8'h00, 32'h0F, 4'h1);
      wr(8'h18, 32'h30, 4'h1);
      rd_check("OUT after SET", 8'h00, 32'h3F);
      wr(8'h1C, 32'h03, 4'h1);
      rd_check("OUT after CLR", 8'h00, 32'h3C);
      check("gpio_out after CLR", 32'(gpio_out), 32'h3C);
      wr(8'h18, 32'hC0, 4'h2);
      rd_check("OUT after SET unselected lane", 8'h00, 32'h3C);
      rd_check("SET reads zero", 8'h18, 32'h0);
`else
      wr(8'h00, 32'h0F, 4'h1);
      wr(8'h18, 32'hFF, 4'hF);
      rd_check("OUT after unmapped 0x18", 8'h00, 32'h0F);
      wr(8'h1C, 32'hFF, 4'hF);
      rd_check("OUT after unmapped 0x1C", 8'h00, 32'h0F);
      check("gpio_out after unmapped", 32'(gpio_out), 32'h0F);
`endif

      // Reset lands on a pending write; pads held high must not log edges afterwards.
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; dat_w = 32'hFF; sel = 4'hF;
      rst = 1'b1;
      gpio_in = 8'hFF;
      @(negedge clk);
      check("ack under reset", 32'(ack), 32'd0);
      check("gpio_out under reset", 32'(gpio_out), 32'h00);
      check("irq under reset", 32'(irq), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      $display("WR adr=0x00 wdat=0x000000ff sel=1111 (lost to reset)");
      idle(3);
      rst = 1'b0;
      idle(10);
      rd_check("ISTAT after blanking", 8'h10, 32'h00);
      rd_check("IN high pads", 8'h04, 32'hFF);
      rd_check("OUT after reset", 8'h00, 32'h00);
      rd_check("DIR after reset", 8'h08, 32'h00);
      rd_check("IPOL after reset", 8'h14, 32'hFF);
      check("gpio_oeb after reset", 32'(gpio_oeb), 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_gpio_n.md
Name: wb_gpio_n

Overview:
Parametrised Wishbone GPIO target that replaces the fixed 4-out/4-in GPIO register in the payload.
- N_GPIO bidirectional pins.
- Per-pin direction control.
- Multi-stage input synchroniser.
- Per-pin edge-detect interrupts with W1C status.
- Sits on one target port of wb_interconnect_NxN. Drives io_out/io_oeb slices and one irq line to the core.

Parameters:
N_GPIO, 8, pin count, 1..32
SYNC_STAGES, 2, input synchroniser depth, 2..4
ADR_WIDTH, 8, target-local address bits decoded (adr_i[ADR_WIDTH-1:0])

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
adr_i  in  ADR_WIDTH  byte address; word-aligned, adr_i[1:0] ignored
dat_w  in  32  write data
dat_r  out  32  read data
cyc  in  1  WB cycle
stb  in  1  WB strobe
we  in  1  write enable
sel  in  4  byte lanes
ack  out  1  WB acknowledge
err  out  1  tied 0
gpio_in  in  N_GPIO  raw pad inputs (asynchronous)
gpio_out  out  N_GPIO  pad output values
gpio_oeb  out  N_GPIO  output-enable-bar; equals ~DIR
irq  out  1  level interrupt, registered

Behaviour:
- Register map (byte offset). Bits above N_GPIO read 0 and ignore writes.
  - 0x00 OUT: rw
  - 0x04 IN: ro; synchronised input
  - 0x08 DIR: rw; 1 = output
  - 0x0C IRQ_EN: rw
  - 0x10 IRQ_STAT: rw1c
  - 0x14 IRQ_POL: rw; 1 = rising edge, 0 = falling edge
- Reset values: OUT=0, DIR=0 (gpio_oeb all 1), IRQ_EN=0, IRQ_STAT=0, IRQ_POL=all 1, ack=0, irq=0, dat_r=0, synchroniser flops=0.
- Handshake:
  - Access accepted on the edge where cyc&stb&~ack. ack goes 1 on that same edge for exactly one cycle.
  - Back-to-back accesses therefore cost 2 cycles each.
  - dat_r is registered on the accept edge and held until the next accept.
- Writes commit on the accept edge. sel[k] gates byte k for rw registers. IRQ_STAT clears bit i iff its byte lane is selected and dat_w[i]=1.
- Unmapped offsets: ack given, read returns 0, write ignored. cyc dropped before ack: no side effect beyond what has already committed.
- Input path: gpio_in passes through SYNC_STAGES flops to produce sync_in. IN reads sync_in. sync_in[i] is reflected SYNC_STAGES cycles after the pad changes.
- Edge detect:
  - prev register holds sync_in of the previous cycle.
  - Rising edge: sync_in&~prev. Falling edge: ~sync_in&prev. IRQ_POL selects which one counts per bit.
  - Only bits with DIR=0 are detected. A detected edge sets IRQ_STAT[i] whether or not IRQ_EN[i] is set.
- Post-reset blanking: a counter suppresses edge detection for SYNC_STAGES+1 cycles after reset deasserts, so a high pad at reset does not log a spurious rising edge.
- Simultaneous edge-set and W1C clear of the same bit: set wins, and the bit stays 1.
- irq <= |(IRQ_STAT & IRQ_EN), registered, so it lags the status change by 1 cycle.
- Reset asserted mid-access: ack forced to 0 next edge, all registers return to reset values, and the access is lost.

Optional Feature:
GPIO_SET_CLR_EN
- Defined: adds write-only 0x18 OUT_SET (OUT |= data) and 0x1C OUT_CLR (OUT &= ~data), sel-gated, reads return 0. A single write is atomic and needs no read-modify-write.
- Undefined: 0x18/0x1C are unmapped.

Decomposition:
- Package wb_gpio_pkg:
  - register offset localparams (GPIO_OUT_OFF, GPIO_IN_OFF, GPIO_DIR_OFF, GPIO_IEN_OFF, GPIO_ISTAT_OFF, GPIO_IPOL_OFF, GPIO_SET_OFF, GPIO_CLR_OFF)
  - reset-value constants
- Sub-module gpio_sync: N-bit, SYNC_STAGES-deep synchroniser chain with synchronous reset. It is instantiated once.

Test Plan:
- Reset, then read all registers -> OUT=0, DIR=0, IRQ_EN=0, IRQ_STAT=0, IRQ_POL=0xFF, gpio_oeb=0xFF, irq=0; each ack is a 1-cycle pulse, 1 cycle after stb.
- Write DIR=0x0F, OUT=0xA5 with sel=4'b0001 -> gpio_oeb=0xF0, gpio_out=0xA5; OUT write with sel=4'b0010 -> OUT unchanged.
- gpio_in 0x00->0x10 with IRQ_EN=0x10 -> IN reads 0x10 after 2 cycles, IRQ_STAT=0x10, irq=1 one cycle later; W1C 0x10 -> irq=0.
- IRQ_POL[4]=0, pad rises then falls -> only the fall sets STAT[4]; a pad edge on a bit with DIR=1 -> no STAT change.
- gpio_in=0xFF held through reset -> IRQ_STAT stays 0 after the blanking window; an edge coinciding with a W1C of the same bit -> bit remains 1.
- With GPIO_SET_CLR_EN: OUT=0x0F, SET 0x30 -> 0x3F, CLR 0x03 -> 0x3C; without the macro, a 0x18 write leaves OUT unchanged and is acked.
